buffer_fifo: RTL and testbench

Parametrised single-clock FIFO that decouples the Fibonacci/Timer producer from the consumer. Generalises the fixed 8x16 producer/consumer buffer to configurable width and depth. Adds occupancy count, an almost-full stall signal for the producer, sticky overflow/underflow error flags and a synchronous flush. Sits between the producer's `data_1`/`data_1_en` output and the consumer's read port.

---
 rtl/buffer_fifo.sv | 98 +++++++++
 tb/tb_buffer_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_fifo.sv
// buffer_fifo: parametrised single-clock FIFO with occupancy count, almost-full stall and sticky error flags.
// Define BUFFER_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module buffer_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     data_1_en,
  input  logic [WIDTH-1:0]         data_1,
  input  logic                     data_2_rd,
  output logic [WIDTH-1:0]         data_2,
  output logic                     data_2_valid,
  output logic                     buffer_empty,
  output logic                     buffer_full,
  output logic                     buffer_almost_full,
  output logic [$clog2(DEPTH):0]   buffer_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;

  // Handshake: a write is taken when data_1_en is high and the FIFO is not full;
  // a read is taken when data_2_rd is high and the FIFO is not empty. Both are
  // judged on the state at the start of the cycle; rejected requests only set
  // the matching sticky error flag.
  assign wr_acc = data_1_en && !buffer_full;
  assign rd_acc = data_2_rd && !buffer_empty;

  assign buffer_count       = count;
  assign buffer_empty       = (count == '0);
  assign buffer_full        = (count == CW'(DEPTH));
  assign buffer_almost_full = (count >= CW'(AF_LEVEL));

  always_ff @(posedge clk) begin
    if (wr_acc && !clear) begin
      mem[wr_ptr] <= data_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= overflow  | (data_1_en & buffer_full);
      underflow <= underflow | (data_2_rd & buffer_empty);
    end
  end

`ifdef BUFFER_FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so reset reads as 0.
  assign data_2       = buffer_empty ? '0 : mem[rd_ptr];
  assign data_2_valid = !buffer_empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_2       <= '0;
      data_2_valid <= 1'b0;
    end else if (clear) begin
      data_2_valid <= 1'b0;
    end else begin
      data_2_valid <= rd_acc;
      if (rd_acc) data_2 <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// tb_buffer_fifo: table-driven vectors plus hand-written corner sequences for buffer_fifo (DEPTH=8, AF_LEVEL=6).
module tb_buffer_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        data_2_rd;
  logic [15:0] data_2;
  logic        data_2_valid;
  logic        buffer_empty;
  logic        buffer_full;
  logic        buffer_almost_full;
  logic [3:0]  buffer_count;
  logic        overflow;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  buffer_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .data_1_en(data_1_en), .data_1(data_1), .data_2_rd(data_2_rd),
    .data_2(data_2), .data_2_valid(data_2_valid),
    .buffer_empty(buffer_empty), .buffer_full(buffer_full),
    .buffer_almost_full(buffer_almost_full), .buffer_count(buffer_count),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clear = 1'b0; data_1_en = 1'b0; data_1 = '0; data_2_rd = 1'b0;
  endtask

  // driver tasks
  task automatic push(input logic [15:0] d);
    data_1_en = 1'b1; data_1 = d;
    step();
    data_1_en = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    e = exp_q.pop_front();
`ifdef BUFFER_FIFO_FWFT_EN
    check(name, {15'd0, data_2_valid, data_2}, {15'd0, 1'b1, e});
    data_2_rd = 1'b1;
    step();
    data_2_rd = 1'b0;
`else
    data_2_rd = 1'b1;
    step();
    data_2_rd = 1'b0;
    check(name, {15'd0, data_2_valid, data_2}, {15'd0, 1'b1, e});
`endif
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    logic        clr, wr;
    logic [15:0] wd;
    logic        rd;
    logic [3:0]  cnt;
    logic        emp, ful, af, ovf, unf, vld;
    logic [15:0] d2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pack_obs(input logic [3:0] cnt, input logic emp, ful, af, ovf, unf,
                                           input logic vld, input logic [15:0] d2);
`ifdef BUFFER_FIFO_FWFT_EN
    return {6'd0, 1'b0, 16'd0, cnt, emp, ful, af, ovf, unf};
`else
    return {6'd0, vld, d2, cnt, emp, ful, af, ovf, unf};
`endif
  endfunction

  initial begin
    logic [15:0] w;
    //               clr  wr    wd        rd   cnt  emp  ful  af   ovf  unf  vld  d2
    vecs.push_back('{1'b0,1'b1,16'd1,     1'b0,4'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd1,     1'b0,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd2,     1'b0,4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd3,     1'b0,4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd5,     1'b0,4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd8,     1'b0,4'd6,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd13,    1'b0,4'd7,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'd21,    1'b0,4'd8,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'hBEEF,  1'b0,4'd8,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b1,16'hBEEF,  1'b1,4'd7,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,16'd1});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd6,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,16'd1});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd5,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd2});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd4,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd3});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd3,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd5});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd8});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd13});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,16'd21});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,16'd21});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,16'd21});
    vecs.push_back('{1'b1,1'b0,16'd0,     1'b0,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'd21});
    vecs.push_back('{1'b0,1'b1,16'h0AAA,  1'b1,4'd1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd21});
    vecs.push_back('{1'b1,1'b1,16'h1234,  1'b0,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'd21});
    vecs.push_back('{1'b0,1'b0,16'd0,     1'b1,4'd0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'd21});
    vecs.push_back('{1'b1,1'b0,16'd0,     1'b0,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'd21});

    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_state",
          {6'd0, data_2_valid, data_2, buffer_count, buffer_empty, buffer_full, buffer_almost_full, overflow, underflow},
          {6'd0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; data_1_en = vecs[i].wr; data_1 = vecs[i].wd; data_2_rd = vecs[i].rd;
      step();
      check($sformatf("vec%0d", i),
            pack_obs(buffer_count, buffer_empty, buffer_full, buffer_almost_full, overflow, underflow,
                     data_2_valid, data_2),
            pack_obs(vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].af, vecs[i].ovf, vecs[i].unf,
                     vecs[i].vld, vecs[i].d2));
    end
    idle();

    // scoreboard: count held at 3 under concurrent read/write, pointers wrap
    for (int i = 0; i < 3; i++) push(16'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom_range(0, 16'hFFFF));
      data_1_en = 1'b1; data_1 = w;
`ifdef BUFFER_FIFO_FWFT_EN
      check($sformatf("stream_data%0d", i), {15'd0, data_2_valid, data_2}, {15'd0, 1'b1, exp_q[0]});
      data_2_rd = 1'b1;
      step();
`else
      data_2_rd = 1'b1;
      step();
      check($sformatf("stream_data%0d", i), {15'd0, data_2_valid, data_2}, {15'd0, 1'b1, exp_q[0]});
`endif
      void'(exp_q.pop_front());
      exp_q.push_back(w);
      check($sformatf("stream_count%0d", i), {28'd0, buffer_count}, 32'd3);
    end
    idle();
    for (int i = 0; i < 3; i++) pop_check($sformatf("drain%0d", i));
    check("drain_empty", {31'd0, buffer_empty}, 32'd1);

    // clear beats a same-cycle write
    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    check("count5", {28'd0, buffer_count}, 32'd5);
    clear = 1'b1; data_1_en = 1'b1; data_1 = 16'h5555;
    step();
    idle();
    exp_q.delete();
    check("clear_wr_count", {30'd0, buffer_empty, 1'b0}, {30'd0, 1'b1, 1'b0} | {28'd0, buffer_count});
    data_2_rd = 1'b1;
    step();
    data_2_rd = 1'b0;
    check("clear_wr_nowrite", {30'd0, underflow, data_2_valid}, {30'd0, 1'b1, 1'b0});
    do_clear();

    // asynchronous reset between edges
    for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i));
    #2 rst = 1'b1;
    #1;
    check("async_rst", {27'd0, buffer_count, buffer_empty}, {27'd0, 4'd0, 1'b1});
    step();
    rst = 1'b0;
    exp_q.delete();
    step();

`ifdef BUFFER_FIFO_FWFT_EN
    push(16'h0007);
    check("fwft_head", {15'd0, data_2_valid, data_2}, {15'd0, 1'b1, 16'h0007});
    pop_check("fwft_pop");
    check("fwft_empty", {31'd0, data_2_valid}, 32'd0);
`else
    push(16'h0007);
    check("std_no_auto_valid", {31'd0, data_2_valid}, 32'd0);
    pop_check("std_pop");
    step();
    check("std_valid_pulse", {15'd0, data_2_valid, data_2}, {15'd0, 1'b0, 16'h0007});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
